// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiplier and restoring divider, one bit per cycle.
// Define MDU_SIGNED_EN to honour the sign input (two's complement operands).
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             divzero
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [1:0]         op_q;
  logic               dz_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               b_zero, last_iter;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_final;

`ifdef MDU_SIGNED_EN
  logic neg_q, res_neg;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Iterate on magnitudes; the sign is restored when the result is registered.
  always_comb begin
    a_mag   = neg_w(A, sign & A[WIDTH-1]);
    b_mag   = neg_w(B, sign & B[WIDTH-1]);
    res_neg = (op == OP_REM) ? (sign & A[WIDTH-1])
                             : (sign & (A[WIDTH-1] ^ B[WIDTH-1]));
  end
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign a_mag       = A;
  assign b_mag       = B;
`endif

  assign b_zero    = op[1] && (B == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A zero divisor spends a single cycle in CALC so FIN timing is shared by both paths.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = CALC;
        CALC:    if (last_iter || dz_q) state_nxt = FIN;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == CALC);
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
`ifdef MDU_SIGNED_EN
    prod_fix = neg_2w(acc, neg_q);
    quo_fix  = neg_w(acc[WIDTH-1:0], neg_q);
    rem_fix  = neg_w(acc[2*WIDTH-1:WIDTH], neg_q);
`else
    prod_fix = acc;
    quo_fix  = acc[WIDTH-1:0];
    rem_fix  = acc[2*WIDTH-1:WIDTH];
`endif
    case (op_q)
      OP_MUL:  res_final = prod_fix[WIDTH-1:0];
      OP_MULH: res_final = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV:  res_final = dz_q ? '1 : quo_fix;
      OP_REM:  res_final = dz_q ? acc[WIDTH-1:0] : rem_fix;
      default: res_final = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op_q    <= '0;
      dz_q    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      result  <= '0;
`ifdef MDU_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (!flush) begin
        case (state)
          IDLE: begin
            if (start) begin
              op_q    <= op;
              cnt     <= '0;
              divzero <= 1'b0;
              dz_q    <= b_zero;
              opnd    <= op[1] ? b_mag : a_mag;
              acc     <= op[1] ? {WIDTH'(0), (b_zero ? A : a_mag)} : {WIDTH'(0), b_mag};
`ifdef MDU_SIGNED_EN
              neg_q   <= res_neg;
`endif
            end
          end
          CALC: begin
            cnt <= cnt + CNT_W'(1);
            if (!dz_q) acc <= op_q[1] ? div_step : mul_step;
          end
          FIN: begin
            done    <= 1'b1;
            divzero <= dz_q;
            result  <= res_final;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
